ram_1p_arbiter: RTL and testbench

- Shares one `ram_1p` instance (single port, 1-cycle read latency, 32-bit words, byte enables) between NumHosts requesters, e.g. the instruction fetch and LSU ports of the core plus a debug/loader port.
- Performs round-robin arbitration with a same-cycle grant.
- Checks each granted address against the RAM depth.
- Routes each response back to the host that issued the request, and flags out-of-range accesses with an error instead of aliasing them into the RAM.

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/ram_arb_rr_pick.sv | 45 ++++
 rtl/ram_1p_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_1p_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
//   host_idx_w : width of a host index for a given host count (minimum 1)
//   ram_req_t  : one host's request fields (we, be, addr, wdata)
//   ram_rsp_t  : response fields routed back to a host (rvalid, err, rdata)
package ram_arb_pkg;

  function automatic int host_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ram_req_t;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } ram_rsp_t;

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational rotate-priority picker.
//   req : request vector, one bit per host
//   ptr : index of the highest-priority host this cycle
//   gnt : one-hot grant (zero when nobody requests)
//   idx : index of the granted host (0 when nobody requests)
//   any : at least one request was granted
module ram_arb_rr_pick #(
  parameter int N    = 2,
  parameter int IdxW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Walk the hosts starting at ptr; ptr is always < N so a single
    // subtraction is enough to wrap.
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IdxW'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_1p_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read latency)
// between NumHosts requesters. Out-of-range word addresses are not forwarded
// to the RAM; they are answered with an error response on the same timing.
//   clk_i / rst_i      : clock, asynchronous active-high reset
//   host_req_i..wdata  : per-host request channel, host_gnt_o grants same cycle
//   host_rvalid_o/err  : per-host response, one cycle after the grant
//   host_rdata_o       : read data broadcast to all hosts
//   dev_*              : request/response channel to the RAM
module ram_1p_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NumHosts = 2,
  parameter int Depth    = 128
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumHosts-1:0]       host_req_i,
  output logic [NumHosts-1:0]       host_gnt_o,
  input  logic [NumHosts-1:0]       host_we_i,
  input  logic [NumHosts-1:0][3:0]  host_be_i,
  input  logic [NumHosts-1:0][31:0] host_addr_i,
  input  logic [NumHosts-1:0][31:0] host_wdata_i,
  output logic [NumHosts-1:0]       host_rvalid_o,
  output logic [NumHosts-1:0]       host_err_o,
  output logic [31:0]               host_rdata_o,
  output logic                      dev_req_o,
  output logic                      dev_we_o,
  output logic [3:0]                dev_be_o,
  output logic [31:0]               dev_addr_o,
  output logic [31:0]               dev_wdata_o,
  input  logic                      dev_rvalid_i,
  input  logic [31:0]               dev_rdata_i
);

  localparam int IdxW = host_idx_w(NumHosts);

  if (NumHosts < 2) begin : g_bad_num_hosts
    $error("ram_1p_arbiter: NumHosts must be at least 2");
  end

  logic [IdxW-1:0] rr_ptr_q;
  logic            pend_valid_q;
  logic [IdxW-1:0] pend_host_q;
  logic            pend_err_q;

  ram_req_t        host_req [NumHosts];
  ram_req_t        sel_req;
  ram_rsp_t        rsp;
  logic [NumHosts-1:0] req_masked;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_any;
  logic            in_range;

  for (genvar gi = 0; gi < NumHosts; gi++) begin : g_host_req
    assign host_req[gi] = '{
      we:    host_we_i[gi],
      be:    host_be_i[gi],
      addr:  host_addr_i[gi],
      wdata: host_wdata_i[gi]
    };
  end

  // No grants while reset is held, so nothing is accepted into the pipeline.
  assign req_masked = host_req_i & {NumHosts{~rst_i}};

  ram_arb_rr_pick #(
    .N    (NumHosts),
    .IdxW (IdxW)
  ) u_pick (
    .req (req_masked),
    .ptr (rr_ptr_q),
    .gnt (host_gnt_o),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign sel_req  = host_req[gnt_idx];
  assign in_range = sel_req.addr[31:2] < 30'(Depth);

  assign dev_req_o   = gnt_any & in_range;
  assign dev_we_o    = dev_req_o & sel_req.we;
  assign dev_be_o    = dev_req_o ? sel_req.be    : 4'h0;
  assign dev_addr_o  = dev_req_o ? sel_req.addr  : 32'h0;
  assign dev_wdata_o = dev_req_o ? sel_req.wdata : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_host_q  <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      if (gnt_any) begin
        rr_ptr_q <= (gnt_idx == IdxW'(NumHosts - 1)) ? '0 : gnt_idx + IdxW'(1);
      end
      // Overwritten every cycle: at most one transaction is ever in flight.
      pend_valid_q <= gnt_any;
      pend_host_q  <= gnt_idx;
      pend_err_q   <= gnt_any & ~in_range;
    end
  end

  // Error responses do not wait for the RAM, which never saw the request.
  assign rsp.rvalid = pend_valid_q & (dev_rvalid_i | pend_err_q);
  assign rsp.err    = pend_err_q;
  assign rsp.rdata  = pend_err_q ? 32'h0 : dev_rdata_i;

  for (genvar gi = 0; gi < NumHosts; gi++) begin : g_host_rsp
    assign host_rvalid_o[gi] = rsp.rvalid & (pend_host_q == IdxW'(gi));
    assign host_err_o[gi]    = host_rvalid_o[gi] & rsp.err;
  end

  assign host_rdata_o = rsp.rdata;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(host_gnt_o));
  a_rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(host_rvalid_o));
  a_rvalid_after_req : assert property (@(posedge clk_i) disable iff (rst_i)
    dev_rvalid_i |-> $past(dev_req_o));
  a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
    dev_rvalid_i |-> (pend_valid_q && !pend_err_q));

endmodule

// File: tb/tb_ram_1p_arbiter.sv
module tb_ram_1p_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 128;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req = '0;
  logic [N-1:0]        we = '0;
  logic [N-1:0][3:0]   be = '0;
  logic [N-1:0][31:0]  addr = '0;
  logic [N-1:0][31:0]  wdata = '0;
  logic [N-1:0]        gnt, rvalid, err;
  logic [31:0]         rdata;
  logic                dev_req, dev_we;
  logic [3:0]          dev_be;
  logic [31:0]         dev_addr, dev_wdata;
  logic                ram_rvalid;
  logic [31:0]         ram_rdata;

  always #5 clk = ~clk;

  ram_1p_arbiter #(.NumHosts(N), .Depth(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host_req_i    (req),
    .host_gnt_o    (gnt),
    .host_we_i     (we),
    .host_be_i     (be),
    .host_addr_i   (addr),
    .host_wdata_i  (wdata),
    .host_rvalid_o (rvalid),
    .host_err_o    (err),
    .host_rdata_o  (rdata),
    .dev_req_o     (dev_req),
    .dev_we_o      (dev_we),
    .dev_be_o      (dev_be),
    .dev_addr_o    (dev_addr),
    .dev_wdata_o   (dev_wdata),
    .dev_rvalid_i  (ram_rvalid),
    .dev_rdata_i   (ram_rdata)
  );

  // Attached single-port RAM, zero-initialised, 1-cycle read latency.
  logic [31:0] ram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rvalid <= 1'b0;
      ram_rdata  <= 32'h0;
    end else begin
      ram_rvalid <= dev_req;
      if (dev_req) begin
        if (dev_we) begin
          for (int b = 0; b < 4; b++)
            if (dev_be[b]) ram_mem[dev_addr[8:2]][8*b +: 8] <= dev_wdata[8*b +: 8];
        end else begin
          ram_rdata <= ram_mem[dev_addr[8:2]];
        end
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  int          rr = 0;
  bit          m_any, m_inr;
  int          m_idx;
  bit          exp_valid, exp_err, exp_read;
  int          exp_host;
  logic [31:0] exp_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_host(input int h, input bit r, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
    req[h] = r; we[h] = w; be[h] = b; addr[h] = a; wdata[h] = d;
  endtask

  // Combinational checks: grant and device-side forwarding.
  task automatic check_comb();
    logic [N-1:0] exp_gnt;
    int h;
    #1;
    m_any = 0; m_idx = 0;
    for (int k = 0; k < N; k++) begin
      h = (rr + k) % N;
      if (!m_any && req[h]) begin m_any = 1; m_idx = h; end
    end
    m_inr   = m_any && ((addr[m_idx] >> 2) < DEPTH);
    exp_gnt = m_any ? (N'(1) << m_idx) : '0;
    chk("gnt", gnt, exp_gnt);
    chk("dev_req", dev_req, m_inr);
    if (m_inr) begin
      chk("dev_we", dev_we, we[m_idx]);
      chk("dev_be", dev_be, be[m_idx]);
      chk("dev_addr", dev_addr, addr[m_idx]);
      chk("dev_wdata", dev_wdata, wdata[m_idx]);
    end else begin
      chk("dev_idle_ctl", {dev_we, dev_be}, 0);
      chk("dev_idle_addr", dev_addr, 0);
      chk("dev_idle_wdata", dev_wdata, 0);
    end
  endtask

  // Clock edge: update the model with the accepted transaction.
  task automatic accept();
    int w;
    @(posedge clk);
    exp_valid = m_any;
    exp_host  = m_idx;
    exp_err   = m_any && !m_inr;
    exp_read  = !we[m_idx];
    exp_rdata = 32'h0;
    if (m_inr) begin
      w = int'(addr[m_idx] >> 2);
      exp_rdata = ref_mem[w];
      if (we[m_idx])
        for (int b = 0; b < 4; b++)
          if (be[m_idx][b]) ref_mem[w][8*b +: 8] = wdata[m_idx][8*b +: 8];
    end
    if (m_any) rr = (m_idx + 1) % N;
  endtask

  // Response check one cycle after the grant.
  task automatic check_rsp();
    logic [N-1:0] exp_rv, exp_e;
    @(negedge clk);
    exp_rv = exp_valid ? (N'(1) << exp_host) : '0;
    exp_e  = exp_err ? exp_rv : '0;
    chk("rvalid", rvalid, exp_rv);
    chk("err", err, exp_e);
    if (exp_valid && (exp_err || exp_read))
      chk("rdata", rdata, exp_err ? 32'h0 : exp_rdata);
    if (exp_valid)
      $display("txn host=%0d we=%0d err=%0d rdata=%h", exp_host, !exp_read, exp_err, rdata);
  endtask

  task automatic step();
    check_comb();
    accept();
    check_rsp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_dev_req", dev_req, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    rr = 0;
    exp_valid = 0;
  endtask

  int word;
  initial begin
    repeat (2) @(negedge clk);

    // Partial-byte write then read-back, plus a host-1 word for later.
    do_reset();
    set_host(0, 1, 1, 4'b0011, 32'h10, 32'hAABBCCDD); step();
    set_host(0, 1, 0, 4'h0, 32'h10, 0); step();
    chk("t1_rdata", rdata, 32'h0000CCDD);
    req = '0;
    set_host(1, 1, 1, 4'hF, 32'h14, 32'h11223344); step();
    req = '0; step();

    // Both hosts continuously: alternating grants, no bubbles.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_host(0, 1, 0, 4'h0, 32'h10, 0);
      set_host(1, 1, 0, 4'h0, 32'h14, 0);
      step();
    end
    req = '0; step();

    // Host 1 alone, then both.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_host(0, c >= 3, 0, 4'h0, 32'h10, 0);
      set_host(1, 1, 0, 4'h0, 32'h14, 0);
      step();
    end
    req = '0; step();

    // Out-of-range read, then a normal read.
    do_reset();
    set_host(0, 1, 0, 4'h0, 32'h200, 0); step();
    chk("t4_err", err, 2'b01);
    chk("t4_rdata", rdata, 0);
    set_host(0, 1, 0, 4'h0, 32'h0, 0); step();
    chk("t4_err_clear", err, 0);

    // Out-of-range write must not alias into word 1.
    set_host(0, 1, 1, 4'hF, 32'h004, 32'h5A5A5A5A); step();
    set_host(0, 1, 1, 4'hF, 32'h204, 32'hDEADBEEF); step();
    set_host(0, 1, 0, 4'h0, 32'h004, 0); step();
    chk("t5_noalias", rdata, 32'h5A5A5A5A);
    req = '0; step();

    // Reset in the cycle after a grant drops the response.
    do_reset();
    set_host(0, 1, 0, 4'h0, 32'h10, 0);
    set_host(1, 1, 0, 4'h0, 32'h14, 0);
    check_comb();
    accept();
    #1 rst = 1'b1;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0; rr = 0; exp_valid = 0;
    check_comb();
    chk("midrst_first_gnt", gnt, 2'b01);
    accept();
    check_rsp();

    // Randomised traffic; hosts hold requests until granted.
    for (int c = 0; c < 600; c++) begin
      if (m_any) req[m_idx] = 1'b0;
      for (int h = 0; h < N; h++) begin
        if (!req[h] && $urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 9))
            0:       addr[h] = $urandom;
            1:       addr[h] = ($urandom_range(128, 300) << 2) | $urandom_range(0, 3);
            default: addr[h] = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
          endcase
          req[h]   = 1'b1;
          we[h]    = $urandom_range(0, 1) == 1;
          be[h]    = 4'($urandom);
          wdata[h] = $urandom;
        end
      end
      step();
    end
    req = '0; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
